rename_reg_file: RTL and testbench

RENAME_REG_FILE -- requirements
Module: rename_reg_file

---
 rtl/rename_reg_file.sv | 98 +++++++++
 tb/tb_rename_reg_file.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_reg_file.sv
// Register-status file for a Tomasulo-style dispatcher: per-register value and
// pending-producer tag, with commit-time read bypass and flush support.
module rename_reg_file #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned NRD     = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              rdy_in,
    input  logic [NRD*$clog2(REG_NUM)-1:0]    rs_in,
    output logic [NRD*XLEN-1:0]               v_out,
    output logic [NRD*TAG_W-1:0]              q_out,
    input  logic                              rename_en_in,
    input  logic [$clog2(REG_NUM)-1:0]        rename_rd_in,
    input  logic [TAG_W-1:0]                  rename_tag_in,
    input  logic                              commit_en_in,
    input  logic [$clog2(REG_NUM)-1:0]        commit_rd_in,
    input  logic [TAG_W-1:0]                  commit_tag_in,
    input  logic [XLEN-1:0]                   commit_val_in,
    input  logic                              rollback_in,
    output logic [$clog2(REG_NUM):0]          busy_cnt_out
);

    localparam int unsigned AW = $clog2(REG_NUM);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0]  v_mem [REG_NUM];
    logic [TAG_W-1:0] q_mem [REG_NUM];
    logic [CW-1:0]    busy_cnt;

    logic             commit_act;
    logic             rename_act;
    logic             commit_clear;
    logic             busy_inc;
    logic             busy_dec_ren;
    logic [TAG_W-1:0] q_commit_rd;
    logic [TAG_W-1:0] q_rename_rd;
    logic [CW-1:0]    busy_nxt;

    // Update qualifiers; a commit only frees the register if no same-cycle rename retargets it.
    always_comb begin
        commit_act   = commit_en_in && (commit_rd_in != '0);
        rename_act   = rename_en_in && (rename_rd_in != '0) && !rollback_in;
        q_commit_rd  = q_mem[commit_rd_in];
        q_rename_rd  = q_mem[rename_rd_in];
        commit_clear = commit_act && (q_commit_rd == commit_tag_in) && (q_commit_rd != '0)
                       && !(rename_act && (rename_rd_in == commit_rd_in));
        busy_inc     = rename_act && (q_rename_rd == '0) && (rename_tag_in != '0);
        busy_dec_ren = rename_act && (q_rename_rd != '0) && (rename_tag_in == '0);
        busy_nxt     = busy_cnt + CW'(busy_inc) - CW'(busy_dec_ren) - CW'(commit_clear);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                v_mem[i] <= '0;
                q_mem[i] <= '0;
            end
            busy_cnt <= '0;
        end else if (rdy_in) begin
            if (commit_act) begin
                v_mem[commit_rd_in] <= commit_val_in;
            end
            if (rollback_in) begin
                for (int unsigned i = 0; i < REG_NUM; i++) begin
                    q_mem[i] <= '0;
                end
                busy_cnt <= '0;
            end else begin
                if (commit_clear) begin
                    q_mem[commit_rd_in] <= '0;
                end
                if (rename_act) begin
                    q_mem[rename_rd_in] <= rename_tag_in;
                end
                busy_cnt <= busy_nxt;
            end
        end
    end

    assign busy_cnt_out = busy_cnt;

    // Combinational read ports; a matching commit forwards its value with the tag cleared.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] rs;
        logic          hit;

        assign rs  = rs_in[k*AW +: AW];
        assign hit = rst_n_in && commit_en_in && (rs != '0) && (commit_rd_in == rs)
                     && (commit_tag_in == q_mem[rs]);

        assign v_out[k*XLEN +: XLEN]   = hit ? commit_val_in : ((rs == '0) ? '0 : v_mem[rs]);
        assign q_out[k*TAG_W +: TAG_W] = (hit || (rs == '0)) ? '0 : q_mem[rs];
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Self-checking bench for rename_reg_file: directed scenarios plus randomized
// traffic compared against an array-based model of the register status file.
module tb_rename_reg_file;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_NUM = 32;
    localparam int unsigned TAG_W   = 5;
    localparam int unsigned NRD     = 2;
    localparam int unsigned AW      = 5;
    localparam int unsigned CW      = AW + 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  rdy;
    logic [NRD*AW-1:0]     rs;
    logic [NRD*XLEN-1:0]   v;
    logic [NRD*TAG_W-1:0]  q;
    logic                  rename_en;
    logic [AW-1:0]         rename_rd;
    logic [TAG_W-1:0]      rename_tag;
    logic                  commit_en;
    logic [AW-1:0]         commit_rd;
    logic [TAG_W-1:0]      commit_tag;
    logic [XLEN-1:0]       commit_val;
    logic                  rollback;
    logic [CW-1:0]         busy;

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0]  mv [REG_NUM];
    logic [TAG_W-1:0] mq [REG_NUM];

    rename_reg_file #(.XLEN(XLEN), .REG_NUM(REG_NUM), .TAG_W(TAG_W), .NRD(NRD)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .rdy_in        (rdy),
        .rs_in         (rs),
        .v_out         (v),
        .q_out         (q),
        .rename_en_in  (rename_en),
        .rename_rd_in  (rename_rd),
        .rename_tag_in (rename_tag),
        .commit_en_in  (commit_en),
        .commit_rd_in  (commit_rd),
        .commit_tag_in (commit_tag),
        .commit_val_in (commit_val),
        .rollback_in   (rollback),
        .busy_cnt_out  (busy)
    );

    always #100 clk = ~clk;

    function automatic void model_reset();
        for (int r = 0; r < REG_NUM; r++) begin
            mv[r] = '0;
            mq[r] = '0;
        end
    endfunction

    function automatic logic [CW-1:0] model_busy();
        int n = 0;
        for (int r = 0; r < REG_NUM; r++) if (mq[r] != '0) n++;
        return CW'(n);
    endfunction

    function automatic logic [XLEN-1:0] exp_v(input int k);
        logic [AW-1:0] a = rs[k*AW +: AW];
        if (commit_en && a != '0 && commit_rd == a && commit_tag == mq[a]) return commit_val;
        return mv[a];
    endfunction

    function automatic logic [TAG_W-1:0] exp_q(input int k);
        logic [AW-1:0] a = rs[k*AW +: AW];
        if (commit_en && a != '0 && commit_rd == a && commit_tag == mq[a]) return '0;
        return mq[a];
    endfunction

    // Architectural effect of one clock edge, taken from the current inputs.
    task automatic model_edge();
        logic clr = 1'b0;
        if (!rdy) return;
        if (commit_en && commit_rd != '0) begin
            clr = (mq[commit_rd] == commit_tag);
            mv[commit_rd] = commit_val;
        end
        if (rollback) begin
            for (int r = 0; r < REG_NUM; r++) mq[r] = '0;
        end else begin
            if (clr) mq[commit_rd] = '0;
            if (rename_en && rename_rd != '0) mq[rename_rd] = rename_tag;
        end
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        rdy = 1'b1; rename_en = 1'b0; rename_rd = '0; rename_tag = '0;
        commit_en = 1'b0; commit_rd = '0; commit_tag = '0; commit_val = '0;
        rollback = 1'b0; rs = '0;
    endtask

    task automatic peek(input int r, output logic [XLEN-1:0] pv, output logic [TAG_W-1:0] pq);
        rs[AW-1:0] = AW'(r);
        #1;
        pv = v[XLEN-1:0];
        pq = q[TAG_W-1:0];
    endtask

    task automatic test_reset();
        rename_en = 1'b1; rename_rd = 5'd5; rename_tag = 5'd3;
        commit_en = 1'b1; commit_rd = 5'd7; commit_tag = '0; commit_val = 32'hFFFF_FFFF;
        rollback = 1'b1; rs = {5'd5, 5'd7};
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < NRD; k++) begin
                checks++;
                if (v[k*XLEN +: XLEN] !== '0 || q[k*TAG_W +: TAG_W] !== '0) begin
                    errors++;
                    $display("FAIL reset_read pass%0d port%0d: got v=%h q=%0d, expected v=0 q=0",
                             pass, k, v[k*XLEN +: XLEN], q[k*TAG_W +: TAG_W]);
                end
            end
            checks++;
            if (busy !== '0) begin
                errors++;
                $display("FAIL reset_busy pass%0d: got %0d, expected 0", pass, busy);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        set_idle();
        #10 rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        rename_en = 1'b1; rename_rd = 5'd5; rename_tag = 5'd3;
        clock_edge();
        checks++;
        if (busy !== model_busy()) begin
            errors++; $display("FAIL bypass_busy_after_rename: got %0d, expected %0d", busy, model_busy());
        end
        set_idle();
        commit_en = 1'b1; commit_rd = 5'd5; commit_tag = 5'd3; commit_val = 32'hDEAD_BEEF;
        rs[AW-1:0] = 5'd5;
        #1;
        checks++;
        if (v[XLEN-1:0] !== exp_v(0) || q[TAG_W-1:0] !== exp_q(0)) begin
            errors++; $display("FAIL bypass_read: got v=%h q=%0d, expected v=%h q=%0d",
                               v[XLEN-1:0], q[TAG_W-1:0], exp_v(0), exp_q(0));
        end
        clock_edge();
        set_idle();
        begin
            logic [XLEN-1:0] pv; logic [TAG_W-1:0] pq;
            peek(5, pv, pq);
            checks++;
            if (pv !== mv[5] || pq !== mq[5] || busy !== model_busy()) begin
                errors++; $display("FAIL bypass_after_commit: got v=%h q=%0d busy=%0d, expected v=%h q=%0d busy=%0d",
                                   pv, pq, busy, mv[5], mq[5], model_busy());
            end
        end
    endtask

    task automatic test_younger_rename();
        logic [XLEN-1:0] pv; logic [TAG_W-1:0] pq;
        rename_en = 1'b1; rename_rd = 5'd5; rename_tag = 5'd3;
        clock_edge();
        rename_tag = 5'd7;
        clock_edge();
        set_idle();
        commit_en = 1'b1; commit_rd = 5'd5; commit_tag = 5'd3; commit_val = 32'h11;
        rs[AW-1:0] = 5'd5;
        #1;
        checks++;
        if (v[XLEN-1:0] !== exp_v(0) || q[TAG_W-1:0] !== exp_q(0)) begin
            errors++; $display("FAIL younger_no_bypass: got v=%h q=%0d, expected v=%h q=%0d",
                               v[XLEN-1:0], q[TAG_W-1:0], exp_v(0), exp_q(0));
        end
        clock_edge();
        set_idle();
        peek(5, pv, pq);
        checks++;
        if (pv !== mv[5] || pq !== mq[5] || busy !== model_busy()) begin
            errors++; $display("FAIL younger_state: got v=%h q=%0d busy=%0d, expected v=%h q=%0d busy=%0d",
                               pv, pq, busy, mv[5], mq[5], model_busy());
        end
    endtask

    task automatic test_x0();
        logic [XLEN-1:0] pv; logic [TAG_W-1:0] pq;
        logic [CW-1:0] busy_before = busy;
        rename_en = 1'b1; rename_rd = '0; rename_tag = 5'd4;
        commit_en = 1'b1; commit_rd = '0; commit_tag = '0; commit_val = 32'hFF;
        rs = '0;
        #1;
        checks++;
        if (v !== '0 || q !== '0) begin
            errors++; $display("FAIL x0_read_same_cycle: got v=%h q=%h, expected 0", v, q);
        end
        clock_edge();
        set_idle();
        peek(0, pv, pq);
        checks++;
        if (pv !== '0 || pq !== '0 || busy !== busy_before) begin
            errors++; $display("FAIL x0_after_edge: got v=%h q=%0d busy=%0d, expected v=0 q=0 busy=%0d",
                               pv, pq, busy, busy_before);
        end
    endtask

    task automatic test_rollback();
        logic [XLEN-1:0] pv; logic [TAG_W-1:0] pq;
        for (int r = 1; r <= 3; r++) begin
            rename_en = 1'b1; rename_rd = AW'(r); rename_tag = TAG_W'(r);
            clock_edge();
        end
        set_idle();
        rollback = 1'b1;
        commit_en = 1'b1; commit_rd = 5'd2; commit_tag = 5'd2; commit_val = 32'h42;
        rename_en = 1'b1; rename_rd = 5'd4; rename_tag = 5'd9;
        clock_edge();
        set_idle();
        checks++;
        if (busy !== '0) begin
            errors++; $display("FAIL rollback_busy: got %0d, expected 0", busy);
        end
        for (int r = 0; r < REG_NUM; r++) begin
            peek(r, pv, pq);
            checks++;
            if (pv !== mv[r] || pq !== mq[r]) begin
                errors++; $display("FAIL rollback_scan x%0d: got v=%h q=%0d, expected v=%h q=%0d",
                                   r, pv, pq, mv[r], mq[r]);
            end
        end
    endtask

    task automatic test_stall();
        logic [XLEN-1:0] pv; logic [TAG_W-1:0] pq;
        rdy = 1'b0;
        rename_en = 1'b1; rename_rd = 5'd6; rename_tag = 5'd2;
        commit_en = 1'b1; commit_rd = 5'd9; commit_tag = '0; commit_val = 32'h55;
        clock_edge();
        set_idle();
        rdy = 1'b0;
        peek(6, pv, pq);
        checks++;
        if (pq !== '0 || busy !== '0) begin
            errors++; $display("FAIL stall_rename_held: got q=%0d busy=%0d, expected q=0 busy=0", pq, busy);
        end
        peek(9, pv, pq);
        checks++;
        if (pv !== mv[9]) begin
            errors++; $display("FAIL stall_commit_held: got v=%h, expected v=%h", pv, mv[9]);
        end
        rdy = 1'b1;
        rename_en = 1'b1; rename_rd = 5'd6; rename_tag = 5'd2;
        clock_edge();
        set_idle();
        peek(6, pv, pq);
        checks++;
        if (pq !== 5'd2 || busy !== CW'(1)) begin
            errors++; $display("FAIL stall_release: got q=%0d busy=%0d, expected q=2 busy=1", pq, busy);
        end
    endtask

    task automatic test_random();
        logic [XLEN-1:0] pv; logic [TAG_W-1:0] pq;
        for (int cyc = 0; cyc < 300; cyc++) begin
            rdy        = ($urandom_range(0, 7) != 0);
            rollback   = ($urandom_range(0, 39) == 0);
            rename_en  = ($urandom_range(0, 3) != 0);
            rename_rd  = AW'($urandom);
            rename_tag = TAG_W'($urandom_range(1, (1 << TAG_W) - 1));
            commit_en  = ($urandom_range(0, 1) != 0);
            commit_rd  = AW'($urandom);
            if ($urandom_range(0, 6) == 0) rename_rd = commit_rd;
            commit_tag = ($urandom_range(0, 1) != 0) ? mq[commit_rd] : TAG_W'($urandom);
            commit_val = $urandom;
            for (int k = 0; k < NRD; k++)
                rs[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? commit_rd : AW'($urandom);
            #1;
            for (int k = 0; k < NRD; k++) begin
                checks++;
                if (v[k*XLEN +: XLEN] !== exp_v(k) || q[k*TAG_W +: TAG_W] !== exp_q(k)) begin
                    errors++; $display("FAIL random_read cyc%0d port%0d: got v=%h q=%0d, expected v=%h q=%0d",
                                       cyc, k, v[k*XLEN +: XLEN], q[k*TAG_W +: TAG_W], exp_v(k), exp_q(k));
                end
            end
            clock_edge();
            checks++;
            if (busy !== model_busy()) begin
                errors++; $display("FAIL random_busy cyc%0d: got %0d, expected %0d", cyc, busy, model_busy());
            end
            if (cyc % 30 == 29) begin
                set_idle();
                for (int r = 0; r < REG_NUM; r++) begin
                    peek(r, pv, pq);
                    checks++;
                    if (pv !== mv[r] || pq !== mq[r]) begin
                        errors++; $display("FAIL random_scan cyc%0d x%0d: got v=%h q=%0d, expected v=%h q=%0d",
                                           cyc, r, pv, pq, mv[r], mq[r]);
                    end
                end
            end
        end
        set_idle();
    endtask

    task automatic test_reset_mid();
        logic [XLEN-1:0] pv; logic [TAG_W-1:0] pq;
        rename_en = 1'b1; rename_rd = 5'd8; rename_tag = 5'd5;
        clock_edge();
        set_idle();
        #50;
        commit_en = 1'b1; commit_rd = 5'd8; commit_tag = '0; commit_val = 32'hCAFE_F00D;
        rename_en = 1'b1; rename_rd = 5'd8; rename_tag = 5'd6;
        rs = {5'd8, 5'd8};
        rst_n = 1'b0;
        #1;
        checks++;
        if (v !== '0 || q !== '0 || busy !== '0) begin
            errors++; $display("FAIL reset_mid_immediate: got v=%h q=%h busy=%0d, expected all 0", v, q, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (v !== '0 || q !== '0 || busy !== '0) begin
            errors++; $display("FAIL reset_mid_held: got v=%h q=%h busy=%0d, expected all 0", v, q, busy);
        end
        @(negedge clk);
        set_idle();
        model_reset();
        #10 rst_n = 1'b1;
        rename_en = 1'b1; rename_rd = 5'd3; rename_tag = 5'd4;
        clock_edge();
        set_idle();
        peek(3, pv, pq);
        checks++;
        if (pq !== mq[3] || busy !== model_busy()) begin
            errors++; $display("FAIL reset_mid_first_edge: got q=%0d busy=%0d, expected q=%0d busy=%0d",
                               pq, busy, mq[3], model_busy());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        test_reset();
        test_bypass();
        test_younger_rename();
        test_x0();
        test_rollback();
        test_stall();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
